ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

PS/2 device-to-host receiver with a small receive FIFO. It samples the asynchronous `ps2_clk`/`ps2_data` pins and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop). Valid scan-code bytes are queued for the keyboard display logic, which reads them through a `ready`/`nextdata_n` pop handshake. It is the stage directly upstream of the scan-code display/decoder block.

## Interface

- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, ≥2.
- `TIMEOUT_CYC`, 50000: `clk` cycles without a `ps2_clk` falling edge before a partial frame is discarded. Counter is 16 bits, so values must be ≤65535.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `nextdata_n`  in  1  active-low pop request.
- `data`  out  8  FIFO head byte; valid only while `ready`=1.
- `ready`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky flag: a valid byte was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse: a complete frame failed the start, stop or parity check.

## Operation

- **Synchronisers**
  - `ps2_clk` passes through 3 flops: s1, s2, s3.
  - `ps2_data` passes through 2 flops: d1, d2.
  - Falling edge `fe` = s3 & ~s2.
- **Deframer**
  - 4-bit bit counter `bitcnt` (0..10) and an 11-bit shift register; on `fe`, d2 is shifted in.
  - `bitcnt`=0: a 0 is accepted as the start bit and `bitcnt` becomes 1. A 1 is ignored and `bitcnt` stays 0.
  - `bitcnt` 1..9: shift in the bit and increment.
  - `bitcnt`=10 (stop bit): evaluate the frame on the same edge, then set `bitcnt` to 0.
    - Valid when start=0, stop=1, and XOR of the 8 data bits and the parity bit = 1.
    - Valid frame with room in the FIFO: push the byte.
    - Valid frame with the FIFO full: drop the byte and set `overflow`.
    - Invalid frame: drop the byte and pulse `frame_err` for one cycle.
- **Timeout**
  - The idle counter clears on each `fe` and counts while `bitcnt`≠0.
  - On reaching `TIMEOUT_CYC`, set `bitcnt` to 0 and discard the partial frame. No `frame_err`.
- **FIFO**
  - Register array with read/write pointers one bit wider than log2(`FIFO_DEPTH`); pointers wrap naturally.
  - Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal.
  - `data` = mem[rptr] (combinational read of a registered array).
  - Pop happens on a rising edge where `nextdata_n`=0 and `ready`=1. Pop with `ready`=0 is ignored.
  - If `nextdata_n` is held low, one entry is popped per cycle.
- **Simultaneous events**
  - Push and pop while full: both happen, the byte is accepted, occupancy is unchanged, and `overflow` is not set.
  - Push and pop while empty: the push is written and the pop is ignored.
  - `overflow` sets on a drop and clears on the next successful pop. If a drop and a pop occur in the same cycle, set wins.
- **Reset**
  - Clears synchronisers (to idle level 1), `bitcnt`, shift register, timeout counter, pointers, all FIFO storage (to 0), `overflow` and `frame_err`.
  - Reset mid-frame discards the partial frame.

## Timing

- Reset values: `data`=8'h00, `ready`=0, `overflow`=0, `frame_err`=0.
- Let the `ps2_clk` pin fall between clk edges E0 and E1.
  - s1 captures it at E1, s2 at E2; `fe` is high between E2 and E3.
  - The bit is consumed at E3.
- For the stop bit, the push occurs at E3: `ready`, `data` and `frame_err` change 3 edges after the pin falls.
- `ps2_data` must be stable across E1–E2 of each falling edge. This is guaranteed by PS/2 timing, since data changes only while `ps2_clk` is high.
- Pop latency: the head advances at the edge that samples `nextdata_n`=0. The new `data`/`ready` are valid in the same cycle after that edge.
- Throughput: one byte per PS/2 frame; pop rate up to one per clk.

## Test plan

- **Single byte:** one frame 0x1C, parity 0, no pop → `ready` 0→1 three edges after the stop-bit falling edge; `data`=0x1C. Then one cycle of `nextdata_n`=0 → `ready`=0.
- **Ordering:** frames 0x1C, 0xF0, 0x1C with `nextdata_n`=1 → after the third frame, `ready`=1. Three single-cycle pops yield 0x1C, 0xF0, 0x1C; `ready`=0 after the third pop.
- **Parity error:** frame 0x1C with parity bit 1 → exactly one `frame_err` pulse; `ready` stays 0.
- **Overflow:** 9 valid frames 0x01..0x09 with no pop (`FIFO_DEPTH`=8) → `overflow`=1 after the 9th. Popping yields 0x01..0x08; `overflow` clears after the first pop.
- **Timeout:** start bit plus 4 data bits, idle for `TIMEOUT_CYC`+10 cycles, then a full frame 0x32 → exactly one byte 0x32 queued; no `frame_err`.
- **Reset mid-frame:** assert `rst` for one cycle after the 6th `ps2_clk` falling edge → all outputs at reset values. The next full frame 0x1B is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host frame receiver feeding a small scan-code FIFO
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] TO = 16'(TIMEOUT_CYC);
  logic s1, s2, s3, d1, d2, fe;
  logic [3:0] bitcnt;
  logic [9:0] shreg;
  logic [10:0] frame;
  logic [15:0] idle;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic stop_edge, valid, timeout, full, pop, push, drop;
  assign fe        = s3 & ~s2;
  assign frame     = {d2, shreg};
  assign stop_edge = fe && bitcnt == 4'd10;
  assign valid     = ~frame[0] & frame[10] & ^frame[9:1];
  assign timeout   = bitcnt != 4'd0 && idle == TO;
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign ready     = wptr != rptr;
  assign data      = mem[rptr[AW-1:0]];
  assign pop       = ~nextdata_n & ready;
  assign push      = stop_edge & valid & (~full | pop);
  assign drop      = stop_edge & valid & full & ~pop;
  // pin synchronisers, idle level 1
  always_ff @(posedge clk) begin
    if (rst) {s1, s2, s3, d1, d2} <= '1;
    else {s1, s2, s3, d1, d2} <= {ps2_clk, s1, s2, ps2_data, d1};
  end
  // deframer: start bit hunt, 10 more bits, frame evaluated on the stop-bit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt <= '0;
      shreg  <= '0;
    end else if (fe) begin
      shreg  <= frame[10:1];
      bitcnt <= bitcnt == 4'd0 ? (d2 ? 4'd0 : 4'd1) : bitcnt == 4'd10 ? 4'd0 : bitcnt + 4'd1;
    end else if (timeout) bitcnt <= '0;
  end
  // idle timer only runs while a frame is partially received
  always_ff @(posedge clk) begin
    if (rst || fe || bitcnt == 4'd0) idle <= '0;
    else idle <= idle + 16'd1;
  end
  // FIFO storage, pointers and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= frame[8:1];
        wptr <= wptr + (AW+1)'(1);
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
      overflow  <= drop | (overflow & ~pop);
      frame_err <= stop_edge & ~valid;
    end
  end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: scoreboard bench driving PS/2 frames and popping the FIFO
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int TO    = 200;
  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, nextdata_n = 1;
  logic [7:0] data;
  logic ready, overflow, frame_err;
  int vectors = 0, miscompares = 0, ferr_cnt = 0, f0;
  logic [7:0] exp_q[$];

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .data(data), .ready(ready), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err) ferr_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 0;
    repeat (8) @(negedge clk);
    ps2_clk = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    bit was;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = 1;
    repeat (4) @(negedge clk);
    was = exp_q.size() != 0;
    if (!bad_par && exp_q.size() < DEPTH) exp_q.push_back(b);
    ps2_clk = 0;
    repeat (2) @(negedge clk);
    chk("ready_before_E3", ready, was);
    chk("ferr_before_E3", frame_err, 0);
    @(negedge clk);
    chk("ready_after_E3", ready, exp_q.size() != 0);
    chk("ferr_after_E3", frame_err, bad_par);
    if (exp_q.size() != 0) chk("head_after_E3", data, exp_q[0]);
    repeat (5) @(negedge clk);
    ps2_clk = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    logic [7:0] e;
    e = 8'h00;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk("pop_ready", ready, 1);
    chk("pop_data", data, e);
    nextdata_n = 0;
    @(negedge clk);
    nextdata_n = 1;
    chk("after_pop_ready", ready, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("after_pop_head", data, exp_q[0]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_ready", ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    // single byte
    send_frame(8'h1C, 0);
    pop_one();
    // ordering
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    chk("order_ready", ready, 1);
    repeat (3) pop_one();
    // parity error
    f0 = ferr_cnt;
    send_frame(8'h1C, 1);
    repeat (3) @(negedge clk);
    chk("perr_pulses", ferr_cnt - f0, 1);
    chk("perr_ready", ready, 0);
    // overflow
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0);
    chk("ovf_set", overflow, 1);
    pop_one();
    chk("ovf_clear", overflow, 0);
    repeat (7) pop_one();
    chk("ovf_drained", ready, 0);
    // timeout discards a partial frame
    f0 = ferr_cnt;
    ps2_bit(0);
    ps2_bit(1);
    ps2_bit(0);
    ps2_bit(1);
    ps2_bit(1);
    repeat (TO + 10) @(negedge clk);
    send_frame(8'h32, 0);
    chk("to_no_ferr", ferr_cnt - f0, 0);
    pop_one();
    // reset mid-frame
    send_frame(8'h55, 0);
    ps2_bit(0);
    ps2_bit(1);
    ps2_bit(1);
    ps2_bit(0);
    ps2_bit(1);
    ps2_bit(1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    send_frame(8'h1B, 0);
    pop_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
